// File: rtl/ir_key_dispatch_if.sv
// Event pop port of ir_key_dispatch: head byte plus valid/ready.
// Ports: evt_valid (FIFO not empty), evt_data (head byte), evt_ready (pop request).
interface ir_key_dispatch_if;
   logic       evt_valid;
   logic [7:0] evt_data;
   logic       evt_ready;

   modport master (
      output evt_valid,
      output evt_data,
      input  evt_ready
   );

   modport slave (
      input  evt_valid,
      input  evt_data,
      output evt_ready
   );
endinterface

// File: rtl/ir_key_dispatch.sv
// IR remote command dispatcher: sync, decode, repeat filter, event FIFO.
// Ports: clock, resetn (async low), ir_ready, ir_data, toggle_out,
//  disp_char, evt (pop port), fifo_count, overflow, ovf_clr, frame_err_cnt.
// Option: IR_FRAME_CHECK_EN enables the complement-byte frame check.
module ir_key_dispatch #(
   parameter int NUM_CH         = 4,
   parameter int FIFO_DEPTH     = 8,
   parameter int KEY_LSB        = 16,
   parameter int HOLDOFF_CYCLES = 1024
) (
   input  logic                        clock,
   input  logic                        resetn,
   input  logic                        ir_ready,
   input  logic [31:0]                 ir_data,
   output logic [NUM_CH-1:0]           toggle_out,
   output logic [7:0]                  disp_char,
   ir_key_dispatch_if.master           evt,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic                        overflow,
   input  logic                        ovf_clr,
   output logic [7:0]                  frame_err_cnt
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
   localparam logic [HW-1:0] HOLD_LD = HW'(HOLDOFF_CYCLES - 1);
   localparam logic [AW:0]   FULL    = (AW+1)'(FIFO_DEPTH);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CAP  = 2'd1;
   localparam logic [1:0] S_FILT = 2'd2;

   logic [2:0]        r_sync;
   logic [1:0]        r_state;
   logic [7:0]        r_cmd;
   logic [3:0]        r_last_key;
   logic [HW-1:0]     r_hold;
   logic [NUM_CH-1:0] r_tog;
   logic [7:0]        r_disp;
   logic [7:0]        r_mem [FIFO_DEPTH];
   logic [AW-1:0]     r_wp;
   logic [AW-1:0]     r_rp;
   logic [AW:0]       r_cnt;
   logic              r_ovf;

   logic              w_rise;
   logic [3:0]        w_key;
   logic              w_rep;
   logic              w_bad;
   logic              w_acc;
   logic              w_full;
   logic              w_pop;
   logic              w_push;
   logic              w_drop;
   logic [7:0]        w_disp;
   logic [NUM_CH-1:0] w_tmask;
   logic              w_unused;

   assign w_rise  = r_sync[1] & ~r_sync[2];
   assign w_key   = r_cmd[3:0];
   assign w_rep   = (r_hold != '0) && (w_key == r_last_key);
   assign w_acc   = (r_state == S_FILT) && !w_bad && !w_rep;
   assign w_full  = (r_cnt == FULL);
   assign w_pop   = (r_cnt != '0) && evt.evt_ready;
   // a full FIFO still takes the push when the head leaves this cycle
   assign w_push  = w_acc && (!w_full || w_pop);
   assign w_drop  = w_acc && w_full && !w_pop;
   assign w_disp  = (w_key <= 4'd9) ? (8'h30 + {4'h0, w_key}) : 8'h00;
   // keys at or above NUM_CH shift the bit out and toggle nothing
   assign w_tmask = NUM_CH'(1) << w_key;
   assign w_unused = ^ir_data;

   assign toggle_out    = r_tog;
   assign disp_char     = r_disp;
   assign fifo_count    = r_cnt;
   assign overflow      = r_ovf;
   assign evt.evt_valid = (r_cnt != '0);
   assign evt.evt_data  = r_mem[r_rp];

`ifdef IR_FRAME_CHECK_EN
   logic [7:0] r_inv;
   logic [7:0] r_err;

   assign w_bad         = (r_inv != ~r_cmd);
   assign frame_err_cnt = r_err;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_inv <= 8'h00;
         r_err <= 8'h00;
      end else begin
         if (r_state == S_CAP)
            r_inv <= ir_data[KEY_LSB+8 +: 8];
         if (r_state == S_FILT && w_bad && r_err != 8'hFF)
            r_err <= r_err + 8'h01;
      end
   end
`else
   assign w_bad         = 1'b0;
   assign frame_err_cnt = 8'h00;
`endif

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_sync     <= '0;
         r_state    <= S_IDLE;
         r_cmd      <= 8'h00;
         r_last_key <= 4'h0;
         r_hold     <= '0;
         r_tog      <= '0;
         r_disp     <= 8'h00;
      end else begin
         r_sync <= {r_sync[1:0], ir_ready};
         unique case (r_state)
            S_IDLE:  if (w_rise) r_state <= S_CAP;
            S_CAP: begin
               r_cmd   <= ir_data[KEY_LSB +: 8];
               r_state <= S_FILT;
            end
            default: r_state <= S_IDLE;
         endcase
         if (w_acc) begin
            r_disp     <= w_disp;
            r_tog      <= r_tog ^ w_tmask;
            r_last_key <= w_key;
            r_hold     <= HOLD_LD;
         end else if (r_hold != '0) begin
            r_hold <= r_hold - 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
         r_ovf <= 1'b0;
      end else begin
         if (w_push) r_wp <= r_wp + 1'b1;
         if (w_pop)  r_rp <= r_rp + 1'b1;
         if (w_push && !w_pop)
            r_cnt <= r_cnt + 1'b1;
         else if (w_pop && !w_push)
            r_cnt <= r_cnt - 1'b1;
         // set beats clear when both land together
         if (w_drop)
            r_ovf <= 1'b1;
         else if (ovf_clr)
            r_ovf <= 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (w_push)
         r_mem[r_wp] <= r_cmd;
   end
endmodule

// File: tb/tb_ir_key_dispatch.sv
// Bench for ir_key_dispatch: directed frames, queue-based reference model,
// per-cycle compare on the falling edge plus literal spot checks.
module tb_ir_key_dispatch;
   localparam int NUM_CH = 4;
   localparam int DEPTH  = 8;
   localparam int HOLD   = 1024;

   typedef struct {
      int          t;
      logic [31:0] d;
   } fr_t;

   logic        clock = 1'b0;
   logic        resetn;
   logic        ir_ready;
   logic [31:0] ir_data;
   logic [3:0]  toggle_out;
   logic [7:0]  disp_char;
   logic [3:0]  fifo_count;
   logic        overflow;
   logic        ovf_clr;
   logic [7:0]  frame_err_cnt;

   ir_key_dispatch_if evt_if ();

   ir_key_dispatch #(
      .NUM_CH(NUM_CH),
      .FIFO_DEPTH(DEPTH),
      .KEY_LSB(16),
      .HOLDOFF_CYCLES(HOLD)
   ) dut (
      .clock(clock),
      .resetn(resetn),
      .ir_ready(ir_ready),
      .ir_data(ir_data),
      .toggle_out(toggle_out),
      .disp_char(disp_char),
      .evt(evt_if),
      .fifo_count(fifo_count),
      .overflow(overflow),
      .ovf_clr(ovf_clr),
      .frame_err_cnt(frame_err_cnt)
   );

   always #10 clock = ~clock;

   int   n_chk = 0;
   int   n_err = 0;
   int   cycle = 0;
   fr_t  pend[$];
   logic [7:0] m_q[$];
   logic [3:0] m_tog;
   logic [7:0] m_disp;
   logic       m_ovf;
   logic [7:0] m_err;
   logic [3:0] m_last_key;
   int         m_last_acc;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp,
                  $time);
      end
   endtask

   function automatic logic [31:0] mk(input logic [7:0] c);
      return {~c, c, 16'h0000};
   endfunction

   task automatic model_reset();
      m_q.delete();
      pend.delete();
      m_tog      = 4'h0;
      m_disp     = 8'h00;
      m_ovf      = 1'b0;
      m_err      = 8'h00;
      m_last_key = 4'h0;
      m_last_acc = -1000000;
   endtask

   // Reference: a frame raised just after a falling edge is acted on at
   // the fifth rising edge (2 sync flops, edge detect, capture, filter).
   always @(posedge clock) begin : mdl
      bit         popd;
      bit         acc;
      bit         bad;
      logic [7:0] c;
      logic [3:0] k;
      cycle = cycle + 1;
      if (resetn) begin
         acc  = 1'b0;
         popd = evt_if.evt_ready && (m_q.size() > 0);
         c    = 8'h00;
         if (pend.size() > 0 && pend[0].t == cycle) begin
            c = pend[0].d[23:16];
            k = c[3:0];
`ifdef IR_FRAME_CHECK_EN
            bad = (pend[0].d[31:24] != ~c);
`else
            bad = 1'b0;
`endif
            pend.pop_front();
            if (bad) begin
               if (m_err != 8'hFF) m_err = m_err + 8'h01;
            end else if (!(k == m_last_key &&
                           (cycle - m_last_acc) < HOLD)) begin
               acc        = 1'b1;
               m_disp     = (k <= 4'd9) ? 8'h30 + {4'h0, k} : 8'h00;
               if (int'(k) < NUM_CH) m_tog = m_tog ^ (4'b0001 << k);
               m_last_key = k;
               m_last_acc = cycle;
            end
         end
         if (popd) void'(m_q.pop_front());
         if (ovf_clr) m_ovf = 1'b0;
         if (acc) begin
            if (m_q.size() < DEPTH) m_q.push_back(c);
            else m_ovf = 1'b1;
         end
      end
   end

   always @(negedge clock) begin
      chk("toggle_out", toggle_out, m_tog);
      chk("disp_char", disp_char, m_disp);
      chk("evt_valid", evt_if.evt_valid, m_q.size() > 0);
      chk("fifo_count", fifo_count, m_q.size());
      chk("overflow", overflow, m_ovf);
      chk("frame_err_cnt", frame_err_cnt, m_err);
      if (m_q.size() > 0)
         chk("evt_data", evt_if.evt_data, m_q[0]);
   end

   task automatic send(input logic [31:0] d, input bit pop);
      @(negedge clock);
      #1;
      ir_data  = d;
      ir_ready = 1'b1;
      pend.push_back('{cycle + 5, d});
      repeat (4) @(negedge clock);
      ir_ready = 1'b0;
      if (pop) evt_if.evt_ready = 1'b1;
      @(negedge clock);
      evt_if.evt_ready = 1'b0;
      repeat (3) @(negedge clock);
   endtask

   task automatic do_reset();
      @(negedge clock);
      #1;
      resetn = 1'b0;
      model_reset();
      repeat (2) @(negedge clock);
      #1;
      resetn = 1'b1;
      repeat (2) @(negedge clock);
   endtask

   logic [7:0] exp_pop[8];

   initial begin
      model_reset();
      resetn           = 1'b0;
      ir_ready         = 1'b0;
      ir_data          = 32'h0;
      ovf_clr          = 1'b0;
      evt_if.evt_ready = 1'b0;
      repeat (3) @(negedge clock);
      chk("rst toggle", toggle_out, 4'h0);
      chk("rst disp", disp_char, 8'h00);
      #1;
      resetn = 1'b1;
      repeat (3) @(negedge clock);

      // T1: reset lands while the FSM sits in CAPTURE
      @(negedge clock);
      #1;
      ir_data  = mk(8'h07);
      ir_ready = 1'b1;
      pend.push_back('{cycle + 5, mk(8'h07)});
      repeat (3) @(negedge clock);
      #1;
      resetn = 1'b0;
      model_reset();
      ir_ready = 1'b0;
      @(negedge clock);
      chk("T1 toggle", toggle_out, 4'h0);
      chk("T1 disp", disp_char, 8'h00);
      chk("T1 count", fifo_count, 4'd0);
      chk("T1 valid", evt_if.evt_valid, 1'b0);
      repeat (2) @(negedge clock);
      #1;
      resetn = 1'b1;
      repeat (3) @(negedge clock);

      // T2: decode key 2
      send(mk(8'h02), 1'b0);
      chk("T2 disp", disp_char, 8'h32);
      chk("T2 toggle", toggle_out, 4'b0100);
      chk("T2 data", evt_if.evt_data, 8'h02);
      chk("T2 count", fifo_count, 4'd1);

      // T3: repeat suppression window
      repeat (90) @(negedge clock);
      send(mk(8'h12), 1'b0);
      chk("T3 rep count", fifo_count, 4'd1);
      chk("T3 rep toggle", toggle_out, 4'b0100);
      repeat (1100) @(negedge clock);
      send(mk(8'h22), 1'b0);
      chk("T3 late toggle", toggle_out, 4'b0000);
      chk("T3 late count", fifo_count, 4'd2);
      send(mk(8'h5C), 1'b0);
      chk("T3 keyC disp", disp_char, 8'h00);
      chk("T3 keyC toggle", toggle_out, 4'b0000);

      // T4: overflow with nine distinct keys, then drain in order
      do_reset();
      for (int i = 1; i <= 9; i++)
         send(mk(8'hA0 + 8'(i)), 1'b0);
      chk("T4 count", fifo_count, 4'd8);
      chk("T4 ovf", overflow, 1'b1);
      chk("T4 disp", disp_char, 8'h39);
      ovf_clr = 1'b1;
      @(negedge clock);
      ovf_clr = 1'b0;
      chk("T4 ovf clr", overflow, 1'b0);
      exp_pop = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8};
      for (int i = 0; i < 8; i++) begin
         chk("T4 pop data", evt_if.evt_data, exp_pop[i]);
         evt_if.evt_ready = 1'b1;
         @(negedge clock);
      end
      evt_if.evt_ready = 1'b0;
      chk("T4 empty", evt_if.evt_valid, 1'b0);
      chk("T4 empty count", fifo_count, 4'd0);

      // T5: push into a full FIFO while popping
      for (int i = 1; i <= 8; i++)
         send(mk(8'hB0 + 8'(i)), 1'b0);
      chk("T5 full", fifo_count, 4'd8);
      send(mk(8'hC0), 1'b1);
      chk("T5 count", fifo_count, 4'd8);
      chk("T5 ovf", overflow, 1'b0);
      chk("T5 head", evt_if.evt_data, 8'hB2);

`ifdef IR_FRAME_CHECK_EN
      // T6: complement byte check
      do_reset();
      send(32'hFD02_0000, 1'b0);
      chk("T6 good toggle", toggle_out, 4'b0100);
      chk("T6 good disp", disp_char, 8'h32);
      send(32'hFF02_0000, 1'b0);
      chk("T6 err cnt", frame_err_cnt, 8'd1);
      chk("T6 bad toggle", toggle_out, 4'b0100);
      chk("T6 bad count", fifo_count, 4'd1);
`endif

      repeat (4) @(negedge clock);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
